// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch front end with prefetch queue and redirect
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] Rom_addr,
    input  logic [31:0] Rom_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [31:0]      fetch_pc;
    logic [31:0]      q_pc    [DEPTH];
    logic [31:0]      q_instr [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             pop;
    logic             push;
    logic             redirect_pc_unused;

    // Low redirect bits are discarded; instructions are always word aligned.
    assign redirect_pc_unused = ^redirect_pc[1:0];

    assign Rom_addr = fetch_pc;
    assign if_valid = (count != '0);
    assign if_instr = q_instr[rd_ptr];
    assign if_pc    = q_pc[rd_ptr];

    assign pop  = if_valid & if_ready;
    // A full queue can still accept a word in the same cycle its head leaves.
    assign push = (count < CNT_MAX) | pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
                wr_ptr   <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // Queue storage needs no reset: entries are only visible while count covers them.
    always_ff @(posedge clk) begin
        if (!rst && !redirect_valid && push) begin
            q_pc[wr_ptr]    <= fetch_pc;
            q_instr[wr_ptr] <= Rom_data;
        end
    end
endmodule
